// File: rtl/sdram_burst_arbiter.sv
// Two-agent Avalon-MM burst arbiter: VGA reads have priority, stream writes are
// protected by a streak limit. Optional ARB_STATS_EN adds saturating burst/starvation counters.
module sdram_burst_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int BCW            = 6,
  parameter int MAX_VGA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     vga_address,
  input  logic              vga_read,
  input  logic [BCW-1:0]    vga_burstcount,
  output logic              vga_waitrequest,
  output logic [DW-1:0]     vga_readdata,
  output logic              vga_readdatavalid,
  input  logic [AW-1:0]     stream_address,
  input  logic              stream_write,
  input  logic [DW-1:0]     stream_writedata,
  input  logic [DW/8-1:0]   stream_byteenable,
  input  logic [BCW-1:0]    stream_burstcount,
  output logic              stream_waitrequest,
  output logic [AW-1:0]     sdram_address,
  output logic              sdram_read,
  output logic              sdram_write,
  output logic [DW-1:0]     sdram_writedata,
  output logic [DW/8-1:0]   sdram_byteenable,
  output logic [BCW-1:0]    sdram_burstcount,
  input  logic [DW-1:0]     sdram_readdata,
  input  logic              sdram_readdatavalid,
  input  logic              sdram_waitrequest,
  output logic              grant_vga,
  output logic              grant_stream,
`ifdef ARB_STATS_EN
  output logic [15:0]       stat_vga_bursts,
  output logic [15:0]       stat_stream_bursts,
  output logic [15:0]       stat_starve_events,
`endif
  output logic [1:0]        arb_state
);

  localparam int SW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic [BCW-1:0] len_q, len_d;
  logic [SW-1:0]  streak_q, streak_d;
  logic           streak_full;
  logic [BCW-1:0] vga_len, stream_len, wr_len;

  // A burstcount of zero is treated as a single beat.
  assign vga_len     = (vga_burstcount == '0) ? BCW'(1) : vga_burstcount;
  assign stream_len  = (stream_burstcount == '0) ? BCW'(1) : stream_burstcount;
  assign wr_len      = (beat_q == '0) ? stream_len : len_q;
  assign streak_full = (streak_q == SW'(MAX_VGA_STREAK));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      len_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    beat_d             = beat_q;
    len_d              = len_q;
    streak_d           = streak_q;
    vga_waitrequest    = 1'b1;
    stream_waitrequest = 1'b1;
    sdram_read         = 1'b0;
    sdram_write        = 1'b0;
    sdram_address      = '0;
    sdram_writedata    = '0;
    sdram_byteenable   = '1;
    sdram_burstcount   = '0;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (vga_read && !(stream_write && streak_full)) begin
          state_d = RD_CMD;
          if (stream_write) streak_d = streak_q + SW'(1);
        end else if (stream_write) begin
          state_d  = WR;
          streak_d = '0;
        end
      end
      RD_CMD: begin
        sdram_address    = vga_address;
        sdram_read       = vga_read;
        sdram_burstcount = vga_burstcount;
        vga_waitrequest  = sdram_waitrequest;
        if (sdram_readdatavalid) beat_d = beat_q + BCW'(1);
        if (vga_read && !sdram_waitrequest) begin
          len_d   = vga_len;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        sdram_address    = vga_address;
        sdram_burstcount = vga_burstcount;
        if (sdram_readdatavalid) begin
          if (beat_q == len_q - BCW'(1)) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BCW'(1);
          end
        end
      end
      WR: begin
        sdram_address      = stream_address;
        sdram_write        = stream_write;
        sdram_writedata    = stream_writedata;
        sdram_byteenable   = stream_byteenable;
        sdram_burstcount   = stream_burstcount;
        stream_waitrequest = sdram_waitrequest;
        // Length is captured from the first accepted beat; gaps keep the grant.
        if (stream_write && !sdram_waitrequest) begin
          if (beat_q == '0) len_d = stream_len;
          if (beat_q == wr_len - BCW'(1)) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_vga         = (state_q == RD_CMD) || (state_q == RD_DATA);
  assign grant_stream      = (state_q == WR);
  assign vga_readdata      = grant_vga ? sdram_readdata : '0;
  assign vga_readdatavalid = grant_vga & sdram_readdatavalid;
  assign arb_state         = state_q;

`ifdef ARB_STATS_EN
  logic vga_done, stream_done, starve_grant;
  assign vga_done     = (state_q == RD_DATA) && (state_d == IDLE);
  assign stream_done  = (state_q == WR) && (state_d == IDLE);
  assign starve_grant = (state_q == IDLE) && (state_d == WR) && vga_read;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_vga_bursts    <= '0;
      stat_stream_bursts <= '0;
      stat_starve_events <= '0;
    end else begin
      if (vga_done && stat_vga_bursts != '1) stat_vga_bursts <= stat_vga_bursts + 16'd1;
      if (stream_done && stat_stream_bursts != '1) stat_stream_bursts <= stat_stream_bursts + 16'd1;
      if (starve_grant && stat_starve_events != '1) stat_starve_events <= stat_starve_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for sdram_burst_arbiter: one task per scenario, inline checks,
// host behaviour driven by hand except for an auto read responder used in arbitration.
module tb_sdram_burst_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BCW = 6;
  localparam int BEW = DW / 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [AW-1:0]   vga_address;
  logic            vga_read;
  logic [BCW-1:0]  vga_burstcount;
  logic            vga_waitrequest;
  logic [DW-1:0]   vga_readdata;
  logic            vga_readdatavalid;
  logic [AW-1:0]   stream_address;
  logic            stream_write;
  logic [DW-1:0]   stream_writedata;
  logic [BEW-1:0]  stream_byteenable;
  logic [BCW-1:0]  stream_burstcount;
  logic            stream_waitrequest;
  logic [AW-1:0]   sdram_address;
  logic            sdram_read;
  logic            sdram_write;
  logic [DW-1:0]   sdram_writedata;
  logic [BEW-1:0]  sdram_byteenable;
  logic [BCW-1:0]  sdram_burstcount;
  logic [DW-1:0]   sdram_readdata;
  logic            sdram_readdatavalid;
  logic            sdram_waitrequest;
  logic            grant_vga;
  logic            grant_stream;
  logic [1:0]      arb_state;
`ifdef ARB_STATS_EN
  logic [15:0]     stat_vga_bursts, stat_stream_bursts, stat_starve_events;
`endif

  logic manual_rdv = 1'b0;
  logic auto_rdv = 1'b0;
  logic host_auto = 1'b0;
  logic acc_seen = 1'b0;
  logic prev_gv = 1'b0;
  logic prev_gs = 1'b0;
  assign sdram_readdatavalid = manual_rdv | auto_rdv;

  int errors = 0;
  int checks = 0;
  int rd_acc = 0;
  int rdv_cnt = 0;
  logic [DW+BEW-1:0] exp_q[$];
  logic [DW+BEW-1:0] obs_q[$];
  logic grant_log[$];

  sdram_burst_arbiter #(.AW(AW), .DW(DW), .BCW(BCW), .MAX_VGA_STREAK(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .vga_address(vga_address), .vga_read(vga_read), .vga_burstcount(vga_burstcount),
    .vga_waitrequest(vga_waitrequest), .vga_readdata(vga_readdata),
    .vga_readdatavalid(vga_readdatavalid),
    .stream_address(stream_address), .stream_write(stream_write),
    .stream_writedata(stream_writedata), .stream_byteenable(stream_byteenable),
    .stream_burstcount(stream_burstcount), .stream_waitrequest(stream_waitrequest),
    .sdram_address(sdram_address), .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_writedata(sdram_writedata), .sdram_byteenable(sdram_byteenable),
    .sdram_burstcount(sdram_burstcount), .sdram_readdata(sdram_readdata),
    .sdram_readdatavalid(sdram_readdatavalid), .sdram_waitrequest(sdram_waitrequest),
    .grant_vga(grant_vga), .grant_stream(grant_stream),
`ifdef ARB_STATS_EN
    .stat_vga_bursts(stat_vga_bursts), .stat_stream_bursts(stat_stream_bursts),
    .stat_starve_events(stat_starve_events),
`endif
    .arb_state(arb_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Passive monitor: read acceptances, forwarded beats, host write beats, grant starts.
  always @(negedge clk) begin
    acc_seen = sdram_read && !sdram_waitrequest;
    if (reset_n) begin
      if (acc_seen) rd_acc++;
      if (vga_readdatavalid) rdv_cnt++;
      if (sdram_write && !sdram_waitrequest) obs_q.push_back({sdram_byteenable, sdram_writedata});
      if (grant_vga && !prev_gv) grant_log.push_back(1'b1);
      if (grant_stream && !prev_gs) grant_log.push_back(1'b0);
    end
    prev_gv = grant_vga;
    prev_gs = grant_stream;
  end

  // Auto host: one readdatavalid beat the cycle after each accepted read command.
  always @(posedge clk) begin
    #1;
    auto_rdv = host_auto && acc_seen;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    vga_read = 1'b0; vga_address = '0; vga_burstcount = '0;
    stream_write = 1'b0; stream_address = '0; stream_writedata = '0;
    stream_byteenable = '0; stream_burstcount = '0;
    sdram_readdata = '0; sdram_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (grant_vga !== 1'b0 || grant_stream !== 1'b0) begin errors++; $display("FAIL reset_grants: got %b%b want 00", grant_vga, grant_stream); end
    checks++; if (vga_waitrequest !== 1'b1 || stream_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait: got %b%b want 11", vga_waitrequest, stream_waitrequest); end
    checks++; if (sdram_read !== 1'b0 || sdram_write !== 1'b0) begin errors++; $display("FAIL reset_cmd: got rd=%b wr=%b want 0 0", sdram_read, sdram_write); end
    checks++; if (vga_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv: got %b want 0", vga_readdatavalid); end
    checks++; if (arb_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", arb_state); end
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (arb_state !== 2'd0 || vga_waitrequest !== 1'b1) begin errors++; $display("FAIL idle_after_reset: state=%0d vwait=%b want 0 1", arb_state, vga_waitrequest); end
  endtask

  task automatic test_vga_burst();
    rd_acc = 0; rdv_cnt = 0;
    tick();
    vga_read = 1'b1; vga_address = 32'h0000_0100; vga_burstcount = 6'd8; sdram_waitrequest = 1'b1;
    @(negedge clk);
    checks++; if (grant_vga !== 1'b0 || sdram_read !== 1'b0) begin errors++; $display("FAIL vga_latency: grant=%b rd=%b want 0 0", grant_vga, sdram_read); end
    tick();
    @(negedge clk);
    checks++; if (grant_vga !== 1'b1 || sdram_read !== 1'b1 || vga_waitrequest !== 1'b1) begin errors++; $display("FAIL vga_cmd_stall: grant=%b rd=%b wait=%b want 1 1 1", grant_vga, sdram_read, vga_waitrequest); end
    checks++; if (sdram_address !== 32'h100 || sdram_burstcount !== 6'd8 || sdram_byteenable !== 4'hF) begin errors++; $display("FAIL vga_cmd_fwd: addr=%h bc=%0d be=%h want 100 8 f", sdram_address, sdram_burstcount, sdram_byteenable); end
    tick();
    tick();
    sdram_waitrequest = 1'b0;
    @(negedge clk);
    checks++; if (vga_waitrequest !== 1'b0) begin errors++; $display("FAIL vga_wait_follow: got %b want 0", vga_waitrequest); end
    tick();
    vga_read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      manual_rdv = 1'b1; sdram_readdata = 32'hD000_0000 + i;
      @(negedge clk);
      checks++; if (vga_readdatavalid !== 1'b1 || vga_readdata !== 32'hD000_0000 + i || grant_vga !== 1'b1 || sdram_read !== 1'b0) begin
        errors++; $display("FAIL vga_beat%0d: rdv=%b data=%h grant=%b rd=%b want 1 %h 1 0", i, vga_readdatavalid, vga_readdata, grant_vga, sdram_read, 32'hD000_0000 + i);
      end
      tick();
    end
    manual_rdv = 1'b0;
    @(negedge clk);
    checks++; if (grant_vga !== 1'b0 || arb_state !== 2'd0) begin errors++; $display("FAIL vga_release: grant=%b state=%0d want 0 0", grant_vga, arb_state); end
    checks++; if (rd_acc !== 1 || rdv_cnt !== 8) begin errors++; $display("FAIL vga_counts: acc=%0d beats=%0d want 1 8", rd_acc, rdv_cnt); end
  endtask

  task automatic test_stream_gap();
    logic [DW-1:0]  d [4];
    logic [BEW-1:0] b [4];
    d[0] = 32'h1111_0000; d[1] = 32'h2222_0001; d[2] = 32'h3333_0002; d[3] = 32'h4444_0003;
    b[0] = 4'hF; b[1] = 4'h3; b[2] = 4'hC; b[3] = 4'h9;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({b[i], d[i]});
    tick();
    sdram_waitrequest = 1'b0;
    stream_write = 1'b1; stream_address = 32'h200; stream_burstcount = 6'd4;
    stream_writedata = d[0]; stream_byteenable = b[0];
    tick();
    @(negedge clk);
    checks++; if (grant_stream !== 1'b1 || stream_waitrequest !== 1'b0 || vga_waitrequest !== 1'b1 || sdram_address !== 32'h200) begin
      errors++; $display("FAIL stream_grant: grant=%b swait=%b vwait=%b addr=%h want 1 0 1 200", grant_stream, stream_waitrequest, vga_waitrequest, sdram_address);
    end
    tick(); stream_writedata = d[1]; stream_byteenable = b[1];
    tick(); stream_write = 1'b0;
    @(negedge clk);
    checks++; if (grant_stream !== 1'b1 || sdram_write !== 1'b0 || vga_waitrequest !== 1'b1) begin errors++; $display("FAIL stream_gap: grant=%b wr=%b vwait=%b want 1 0 1", grant_stream, sdram_write, vga_waitrequest); end
    tick(); stream_write = 1'b1; stream_writedata = d[2]; stream_byteenable = b[2];
    tick(); stream_writedata = d[3]; stream_byteenable = b[3];
    @(negedge clk);
    checks++; if (grant_stream !== 1'b1 || vga_waitrequest !== 1'b1) begin errors++; $display("FAIL stream_last_beat: grant=%b vwait=%b want 1 1", grant_stream, vga_waitrequest); end
    tick(); stream_write = 1'b0;
    @(negedge clk);
    checks++; if (grant_stream !== 1'b0 || arb_state !== 2'd0) begin errors++; $display("FAIL stream_release: grant=%b state=%0d want 0 0", grant_stream, arb_state); end
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL stream_beat_count: got %0d want 4", obs_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_arbitration();
    logic exp_g [10];
    bit   done;
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    grant_log.delete();
    done = 1'b0;
    tick();
    host_auto = 1'b1; sdram_waitrequest = 1'b0;
    vga_read = 1'b1; vga_burstcount = 6'd1; vga_address = 32'h400;
    stream_write = 1'b1; stream_burstcount = 6'd1; stream_writedata = 32'hCAFE_0000; stream_byteenable = 4'hF;
    for (int c = 0; c < 80 && !done; c++) begin
      tick();
      if (arb_state == 2'd0 && grant_log.size() >= 10) begin
        vga_read = 1'b0; stream_write = 1'b0; done = 1'b1;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL arb_timeout: grants=%0d want 10 within 80 cycles", grant_log.size()); end
    tick();
    host_auto = 1'b0;
    checks++; if (grant_log.size() != 10) begin errors++; $display("FAIL arb_grant_count: got %0d want 10", grant_log.size()); end
    else begin
      for (int i = 0; i < 10; i++) begin
        checks++; if (grant_log[i] !== exp_g[i]) begin errors++; $display("FAIL arb_grant%0d: got vga=%b want vga=%b", i, grant_log[i], exp_g[i]); end
      end
    end
`ifdef ARB_STATS_EN
    checks++; if (stat_starve_events !== 16'd2 || stat_vga_bursts !== 16'd9 || stat_stream_bursts !== 16'd3) begin
      errors++; $display("FAIL arb_stats: starve=%0d vga=%0d stream=%0d want 2 9 3", stat_starve_events, stat_vga_bursts, stat_stream_bursts);
    end
`endif
  endtask

  task automatic test_stream_waits_read();
    tick();
    sdram_waitrequest = 1'b0;
    vga_read = 1'b1; vga_burstcount = 6'd6; vga_address = 32'h500;
    tick();
    tick();
    vga_read = 1'b0;
    stream_write = 1'b1; stream_burstcount = 6'd1; stream_writedata = 32'hBEEF_0001; stream_byteenable = 4'hF;
    for (int i = 0; i < 6; i++) begin
      manual_rdv = 1'b1; sdram_readdata = 32'hE000_0000 + i;
      @(negedge clk);
      checks++; if (stream_waitrequest !== 1'b1 || grant_stream !== 1'b0 || grant_vga !== 1'b1) begin
        errors++; $display("FAIL hold_beat%0d: swait=%b gs=%b gv=%b want 1 0 1", i, stream_waitrequest, grant_stream, grant_vga);
      end
      tick();
    end
    manual_rdv = 1'b0;
    @(negedge clk);
    checks++; if (grant_vga !== 1'b0 || grant_stream !== 1'b0 || stream_waitrequest !== 1'b1) begin errors++; $display("FAIL hold_idle_gap: gv=%b gs=%b swait=%b want 0 0 1", grant_vga, grant_stream, stream_waitrequest); end
    tick();
    @(negedge clk);
    checks++; if (grant_stream !== 1'b1 || stream_waitrequest !== 1'b0) begin errors++; $display("FAIL hold_stream_grant: gs=%b swait=%b want 1 0", grant_stream, stream_waitrequest); end
    tick();
    stream_write = 1'b0;
    @(negedge clk);
    checks++; if (grant_stream !== 1'b0 || arb_state !== 2'd0) begin errors++; $display("FAIL hold_stream_done: gs=%b state=%0d want 0 0", grant_stream, arb_state); end
  endtask

  task automatic test_reset_mid_write();
    tick();
    sdram_waitrequest = 1'b0;
    stream_write = 1'b1; stream_burstcount = 6'd8; stream_address = 32'h600;
    stream_writedata = 32'h7000_0000; stream_byteenable = 4'hF;
    tick();
    tick(); stream_writedata = 32'h7000_0001;
    tick(); stream_writedata = 32'h7000_0002;
    reset_n = 1'b0;
    #1;
    checks++; if (sdram_write !== 1'b0 || stream_waitrequest !== 1'b1 || vga_waitrequest !== 1'b1) begin
      errors++; $display("FAIL midrst_outputs: wr=%b swait=%b vwait=%b want 0 1 1", sdram_write, stream_waitrequest, vga_waitrequest);
    end
    checks++; if (arb_state !== 2'd0 || grant_stream !== 1'b0) begin errors++; $display("FAIL midrst_state: state=%0d gs=%b want 0 0", arb_state, grant_stream); end
    stream_write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back({4'hF, 32'hA0A0_0000});
    exp_q.push_back({4'h5, 32'hA0A0_0001});
    tick();
    stream_write = 1'b1; stream_burstcount = 6'd2; stream_writedata = 32'hA0A0_0000; stream_byteenable = 4'hF;
    tick();
    tick(); stream_writedata = 32'hA0A0_0001; stream_byteenable = 4'h5;
    @(negedge clk);
    checks++; if (grant_stream !== 1'b1) begin errors++; $display("FAIL midrst_fresh_beat2: gs=%b want 1", grant_stream); end
    tick(); stream_write = 1'b0;
    @(negedge clk);
    checks++; if (grant_stream !== 1'b0 || arb_state !== 2'd0) begin errors++; $display("FAIL midrst_fresh_done: gs=%b state=%0d want 0 0", grant_stream, arb_state); end
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL midrst_fresh_count: got %0d want 2", obs_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_fresh%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_zero_burst();
    rdv_cnt = 0;
    tick();
    sdram_waitrequest = 1'b0;
    vga_read = 1'b1; vga_burstcount = 6'd0; vga_address = 32'h300;
    tick();
    @(negedge clk);
    checks++; if (sdram_read !== 1'b1 || sdram_burstcount !== 6'd0) begin errors++; $display("FAIL zero_vga_cmd: rd=%b bc=%0d want 1 0", sdram_read, sdram_burstcount); end
    tick();
    vga_read = 1'b0; manual_rdv = 1'b1; sdram_readdata = 32'h5A5A_5A5A;
    @(negedge clk);
    checks++; if (vga_readdatavalid !== 1'b1 || vga_readdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL zero_vga_beat: rdv=%b data=%h want 1 5a5a5a5a", vga_readdatavalid, vga_readdata); end
    tick();
    manual_rdv = 1'b0;
    @(negedge clk);
    checks++; if (grant_vga !== 1'b0 || arb_state !== 2'd0 || rdv_cnt !== 1) begin errors++; $display("FAIL zero_vga_done: gv=%b state=%0d beats=%0d want 0 0 1", grant_vga, arb_state, rdv_cnt); end
    obs_q.delete();
    tick();
    stream_write = 1'b1; stream_burstcount = 6'd0; stream_writedata = 32'h0BAD_F00D; stream_byteenable = 4'hF;
    tick();
    tick();
    stream_write = 1'b0;
    @(negedge clk);
    checks++; if (grant_stream !== 1'b0 || arb_state !== 2'd0 || obs_q.size() != 1) begin errors++; $display("FAIL zero_stream_done: gs=%b state=%0d beats=%0d want 0 0 1", grant_stream, arb_state, obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_vga_burst();
    test_stream_gap();
    test_arbitration();
    test_stream_waits_read();
    test_reset_mid_write();
    test_zero_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
